// File: rtl/impact_sram_pkg.sv
// Shared types and sizing for the IMPACT SRAM access sequencer.
package impact_sram_pkg;

  localparam int IMPACT_WORDS  = 32;
  localparam int IMPACT_ADDR_W = 5;
  localparam int IMPACT_CNT_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ACC,
    REC,
    RESP
  } state_t;

  // Phase counter reload value for a phase lasting cyc cycles.
  function automatic logic [IMPACT_CNT_W-1:0] cnt_load(input int cyc);
    return IMPACT_CNT_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/impact_wl_decoder.sv
// Address-to-word-line one-hot decoder; all lines low when disabled.
module impact_wl_decoder
  import impact_sram_pkg::*;
(
  input  logic [IMPACT_ADDR_W-1:0] addr,
  input  logic                     en,
  output logic [IMPACT_WORDS-1:0]  wl
);

  for (genvar gi = 0; gi < IMPACT_WORDS; gi++) begin : g_dec
    assign wl[gi] = en && (addr == IMPACT_ADDR_W'(gi));
  end

endmodule

// File: rtl/impact_sram_seq.sv
// Single-access SRAM sequencer: precharge, word-line access, recovery, then
// a held response. Array-facing outputs are registered from the next state.
module impact_sram_seq
  import impact_sram_pkg::*;
#(
  parameter int PRE_CYC = 2,
  parameter int WL_CYC  = 3,
  parameter int REC_CYC = 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] wl_o,
  output logic [31:0] bl_o,
  output logic [31:0] blb_o,
  output logic        bl_oe,
  input  logic [31:0] bl_i,
  input  logic [31:0] blb_i,
  output logic        busy
);

  if (PRE_CYC < 1 || PRE_CYC > 15 || WL_CYC < 1 || WL_CYC > 15 ||
      REC_CYC < 1 || REC_CYC > 15) begin : g_bad_param
    $error("impact_sram_seq: phase cycle parameters must lie in 1..15");
  end

  state_t                    state_reg, state_next;
  logic [IMPACT_CNT_W-1:0]   cnt_reg, cnt_next;
  logic                      we_reg;
  logic [IMPACT_ADDR_W-1:0]  addr_reg;
  logic [31:0]               wdata_reg;
  logic                      bl_oe_next;
  logic [31:0]               bl_next, blb_next, wl_next;
  logic                      wl_en;
  logic                      capture;

  assign req_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign capture   = (state_reg == ACC) && (cnt_reg == '0);
  assign wl_en     = (state_next == ACC);

  impact_wl_decoder u_wl_dec (
    .addr (addr_reg),
    .en   (wl_en),
    .wl   (wl_next)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: if (req_valid) begin
        state_next = PRE;
        cnt_next   = cnt_load(PRE_CYC);
      end
      PRE: if (cnt_reg == '0) begin
        state_next = ACC;
        cnt_next   = cnt_load(WL_CYC);
      end else begin
        cnt_next = cnt_reg - IMPACT_CNT_W'(1);
      end
      ACC: if (cnt_reg == '0) begin
        state_next = REC;
        cnt_next   = cnt_load(REC_CYC);
      end else begin
        cnt_next = cnt_reg - IMPACT_CNT_W'(1);
      end
      REC: if (cnt_reg == '0) begin
        state_next = RESP;
        cnt_next   = '0;
      end else begin
        cnt_next = cnt_reg - IMPACT_CNT_W'(1);
      end
      RESP: if (rsp_ready) begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    // Drive values follow the state being entered so they line up with it.
    bl_oe_next = 1'b0;
    bl_next    = '0;
    blb_next   = '0;
    case (state_next)
      PRE: begin
        bl_oe_next = 1'b1;
        bl_next    = '1;
        blb_next   = '1;
      end
      ACC: if (we_reg) begin
        bl_oe_next = 1'b1;
        bl_next    = wdata_reg;
        blb_next   = ~wdata_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wl_o      <= '0;
      bl_oe     <= 1'b0;
      bl_o      <= '0;
      blb_o     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      wl_o      <= wl_next;
      bl_oe     <= bl_oe_next;
      bl_o      <= bl_next;
      blb_o     <= blb_next;
      rsp_valid <= (state_next == RESP);
      if (req_ready && req_valid) begin
        we_reg    <= req_we;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
      end
      // Sensed data is only trusted at the end of the word-line window.
      if (capture) begin
        if (we_reg) begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end else begin
          rsp_rdata <= bl_i & ~blb_i;
          rsp_err   <= |(~(bl_i ^ blb_i));
        end
      end
    end
  end

endmodule

// File: tb/tb_impact_sram_seq.sv
// Directed bench for impact_sram_seq: default timing instance plus a 1/1/1 instance.
module tb_impact_sram_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err, bl_oe, busy;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata, rsp_rdata, wl_o, bl_o, blb_o, bl_i, blb_i;

  logic        req_valid_b, req_ready_b, req_we_b, rsp_valid_b, rsp_ready_b, rsp_err_b;
  logic        bl_oe_b, busy_b;
  logic [4:0]  req_addr_b;
  logic [31:0] req_wdata_b, rsp_rdata_b, wl_o_b, bl_o_b, blb_o_b, bl_i_b, blb_i_b;

  int n_chk  = 0;
  int n_pass = 0;

  impact_sram_seq u_dut (
    .wb_clk_i (clk),        .wb_rst_n  (rst_n),
    .req_valid(req_valid),  .req_ready (req_ready), .req_we   (req_we),
    .req_addr (req_addr),   .req_wdata (req_wdata),
    .rsp_valid(rsp_valid),  .rsp_ready (rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),    .wl_o      (wl_o),      .bl_o     (bl_o),
    .blb_o    (blb_o),      .bl_oe     (bl_oe),     .bl_i     (bl_i),
    .blb_i    (blb_i),      .busy      (busy)
  );

  impact_sram_seq #(.PRE_CYC(1), .WL_CYC(1), .REC_CYC(1)) u_dut_fast (
    .wb_clk_i (clk),          .wb_rst_n  (rst_n),
    .req_valid(req_valid_b),  .req_ready (req_ready_b), .req_we   (req_we_b),
    .req_addr (req_addr_b),   .req_wdata (req_wdata_b),
    .rsp_valid(rsp_valid_b),  .rsp_ready (rsp_ready_b), .rsp_rdata(rsp_rdata_b),
    .rsp_err  (rsp_err_b),    .wl_o      (wl_o_b),      .bl_o     (bl_o_b),
    .blb_o    (blb_o_b),      .bl_oe     (bl_oe_b),     .bl_i     (bl_i_b),
    .blb_i    (blb_i_b),      .busy      (busy_b)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Per-cycle safety checks on both instances.
  task automatic monitor();
    chk1("wl_multi_hot_a", ($countones(wl_o) > 1), 1'b0);
    chk1("wl_during_pre_a", (bl_oe && (bl_o == '1) && (blb_o == '1) && (wl_o != '0)), 1'b0);
    chk1("wl_multi_hot_b", ($countones(wl_o_b) > 1), 1'b0);
    chk1("wl_during_pre_b", (bl_oe_b && (bl_o_b == '1) && (blb_o_b == '1) && (wl_o_b != '0)), 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  // One access on the default instance; REC-cycle bit lines are scrambled to catch late capture.
  task automatic access_a(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                          input logic [31:0] bli, input logic [31:0] blbi,
                          input logic [31:0] exp_rd, input logic exp_err, input int hold);
    logic [31:0] exp_wl;
    exp_wl = 32'h1 << addr;
    chk1("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    bl_i = bli; blb_i = blbi;
    tick();
    req_valid = 1'b0; req_addr = 5'd0; req_wdata = 32'h0;
    for (int k = 1; k <= 6; k++) begin
      chk1("busy_access", busy, 1'b1);
      chk1("rsp_valid_early", rsp_valid, 1'b0);
      chk1("req_ready_busy", req_ready, 1'b0);
      if (k <= 2) begin
        chk32("pre_wl", wl_o, 32'h0);
        chk1("pre_bl_oe", bl_oe, 1'b1);
        chk32("pre_bl", bl_o, 32'hFFFF_FFFF);
        chk32("pre_blb", blb_o, 32'hFFFF_FFFF);
      end else if (k <= 5) begin
        chk32("acc_wl", wl_o, exp_wl);
        chk1("acc_bl_oe", bl_oe, we);
        if (we) begin
          chk32("acc_bl", bl_o, wdata);
          chk32("acc_blb", blb_o, ~wdata);
        end
      end else begin
        chk32("rec_wl", wl_o, 32'h0);
        chk1("rec_bl_oe", bl_oe, 1'b0);
        bl_i = ~bli; blb_i = ~blbi;
        if (hold > 0) rsp_ready = 1'b0;
      end
      tick();
    end
    chk1("rsp_valid_t7", rsp_valid, 1'b1);
    chk32("rsp_rdata", rsp_rdata, exp_rd);
    chk1("rsp_err", rsp_err, exp_err);
    for (int h = 1; h <= hold; h++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd9;
      tick();
      chk1("hold_rsp_valid", rsp_valid, 1'b1);
      chk32("hold_rsp_rdata", rsp_rdata, exp_rd);
      chk1("hold_rsp_err", rsp_err, exp_err);
      chk1("hold_req_ready", req_ready, 1'b0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chk1("req_ready_after_rsp", req_ready, 1'b1);
    chk1("rsp_valid_dropped", rsp_valid, 1'b0);
    tick();
    chk1("idle_no_queued_req", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1; bl_i = '0; blb_i = '0;
    req_valid_b = 1'b0; req_we_b = 1'b0; req_addr_b = '0; req_wdata_b = '0;
    rsp_ready_b = 1'b1; bl_i_b = '0; blb_i_b = '0;
    #2;
    chk32("reset_wl", wl_o, 32'h0);
    chk1("reset_bl_oe", bl_oe, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_rsp_valid", rsp_valid, 1'b0);
    chk1("reset_req_ready", req_ready, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Write, defaults.
    access_a(1'b1, 5'd5, 32'hA5A5_0F0F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 0);
    // Clean differential read at the top word line.
    access_a(1'b0, 5'd31, 32'h0, 32'h1234_5678, 32'hEDCB_A987, 32'h1234_5678, 1'b0, 0);

    // Reset while the word line is up.
    chk1("rst_req_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd7; req_wdata = 32'h3C3C_C3C3;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    chk32("rst_pre_acc_wl", wl_o, 32'h0000_0080);
    chk1("rst_pre_acc_oe", bl_oe, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk32("rst_async_wl", wl_o, 32'h0);
    chk1("rst_async_bl_oe", bl_oe, 1'b0);
    chk32("rst_async_bl", bl_o, 32'h0);
    chk32("rst_async_blb", blb_o, 32'h0);
    chk1("rst_async_busy", busy, 1'b0);
    chk1("rst_async_rsp_valid", rsp_valid, 1'b0);
    chk32("rst_async_rdata", rsp_rdata, 32'h0);
    chk1("rst_async_err", rsp_err, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk1("rst_no_rsp", rsp_valid, 1'b0);
      chk1("rst_stays_idle", busy, 1'b0);
    end

    // Non-differential columns everywhere.
    access_a(1'b0, 5'd3, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0 ^ 1'b1, 0);
    // Mixed columns, response held off for 4 cycles with a stray request.
    access_a(1'b0, 5'd12, 32'h0, 32'h8000_0003, 32'h7FFF_FFFE, 32'h8000_0001, 1'b1, 4);

    // Minimum timing instance.
    chk1("fast_req_ready", req_ready_b, 1'b1);
    req_valid_b = 1'b1; req_we_b = 1'b0; req_addr_b = 5'd17;
    bl_i_b = 32'h0F0F_0000; blb_i_b = 32'hF0F0_FFFF;
    tick();
    req_valid_b = 1'b0;
    chk1("fast_pre_oe", bl_oe_b, 1'b1);
    chk32("fast_pre_wl", wl_o_b, 32'h0);
    chk1("fast_pre_rsp", rsp_valid_b, 1'b0);
    tick();
    chk32("fast_acc_wl", wl_o_b, 32'h0002_0000);
    chk1("fast_acc_oe", bl_oe_b, 1'b0);
    chk1("fast_acc_rsp", rsp_valid_b, 1'b0);
    tick();
    chk32("fast_rec_wl", wl_o_b, 32'h0);
    chk1("fast_rec_rsp", rsp_valid_b, 1'b0);
    tick();
    chk1("fast_rsp_t4", rsp_valid_b, 1'b1);
    chk32("fast_rdata", rsp_rdata_b, 32'h0F0F_0000);
    chk1("fast_err", rsp_err_b, 1'b0);
    tick();
    chk1("fast_req_ready_after", req_ready_b, 1'b1);
    chk1("fast_rsp_dropped", rsp_valid_b, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/impact_sram_seq.md
IMPACT_SRAM_SEQ -- requirements
Module: impact_sram_seq

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- PRE_CYC, 2, precharge cycles, legal range 1..15.
- WL_CYC, 3, word-line assert cycles, legal range 1..15.
- REC_CYC, 1, recovery cycles, legal range 1..15.

REQ-002 The block SHALL expose these ports (name, direction, width, meaning):
- wb_clk_i, in, 1, the single clock.
- wb_rst_n, in, 1, reset, asynchronous and active-low.
- req_valid, in, 1, access request.
- req_ready, out, 1, request accepted when high together with req_valid.
- req_we, in, 1, 1 = write, 0 = read.
- req_addr, in, 5, word-line index.
- req_wdata, in, 32, write data.
- rsp_valid, out, 1, response available.
- rsp_ready, in, 1, response consumed.
- rsp_rdata, out, 32, read data.
- rsp_err, out, 1, at least one read column was non-differential.
- wl_o, out, 32, one-hot word lines driven to the array East edge.
- bl_o, out, 32, bit-line drive values (West).
- blb_o, out, 32, complement bit-line drive values (South).
- bl_oe, out, 1, bit-line driver enable.
- bl_i, in, 32, sensed bit lines.
- blb_i, in, 32, sensed complement bit lines.
- busy, out, 1, high in any state other than IDLE.

Function
REQ-003 The FSM SHALL have exactly five states: IDLE, PRE, ACC, REC and RESP.
REQ-004 req_ready SHALL be 1 only in IDLE; a handshake SHALL latch req_we, req_addr and req_wdata and move the FSM to PRE on the next edge.
REQ-005 In PRE the block SHALL drive bl_oe=1, bl_o=blb_o=32'hFFFFFFFF and wl_o=0 for exactly PRE_CYC cycles.
REQ-006 In ACC the block SHALL drive wl_o = 1 << addr for exactly WL_CYC cycles.
REQ-007 A write in ACC SHALL drive bl_oe=1, bl_o=wdata and blb_o=~wdata.
REQ-008 A read in ACC SHALL drive bl_oe=0.
REQ-009 A read SHALL capture data on the last ACC cycle:
- rdata[i] = bl_i[i] & ~blb_i[i].
- rsp_err = OR over all i of ~(bl_i[i] ^ blb_i[i]).
REQ-010 In REC the block SHALL drive wl_o=0 and bl_oe=0 for exactly REC_CYC cycles.
REQ-011 wl_o SHALL never be nonzero in the same cycle as PRE drive values.
REQ-012 wl_o SHALL have at most one bit set in every cycle.
REQ-013 In RESP, rsp_valid SHALL be 1 and hold rsp_rdata and rsp_err stable until rsp_ready=1; the FSM SHALL return to IDLE on the next edge.
REQ-014 A write response SHALL report rsp_rdata=0 and rsp_err=0.
REQ-015 With a handshake in cycle T, rsp_valid SHALL first be high at T+PRE_CYC+WL_CYC+REC_CYC+1; with default parameters this is T+7.
REQ-016 When rsp_valid and rsp_ready are high in cycle N, req_ready SHALL be high in cycle N+1; back-to-back accesses carry no extra gap.
REQ-017 A request presented while busy=1 SHALL be ignored, not queued.
REQ-018 Outputs SHALL be registered, except req_ready and busy, which SHALL decode directly from the state register.
REQ-019 The shared phase counter SHALL be 4 bits wide, load parameter-1 on each state entry, and advance the state at 0.
REQ-020 Elaboration SHALL fail for any parameter outside 1..15.

Reset
REQ-021 Asserting wb_rst_n low SHALL immediately force the following, including mid-access:
- state = IDLE, counter = 0.
- wl_o = 0, bl_oe = 0, bl_o = 0, blb_o = 0.
- rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-022 An access interrupted by reset SHALL produce no response.
REQ-023 The first request after reset deassertion SHALL be accepted no earlier than the first rising edge with wb_rst_n high.

Structure
REQ-024 Package impact_sram_pkg SHALL hold:
- the state enum.
- IMPACT_WORDS=32.
- IMPACT_ADDR_W=5.
- IMPACT_CNT_W=4.
REQ-025 The one-hot decode SHALL live in sub-module impact_wl_decoder (5-bit address plus enable in, 32-bit one-hot out, zero when enable is low).

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Write addr=5, wdata=32'hA5A5_0F0F, defaults: wl_o=32'h20 for 3 cycles; bl_o=32'hA5A5_0F0F and blb_o=32'h5A5A_F0F0 during ACC; rsp_valid at T+7, rsp_rdata=0.
- Read addr=31 with bl_i=32'h1234_5678 and blb_i=~bl_i: wl_o=32'h8000_0000; rsp_rdata=32'h1234_5678, rsp_err=0.
- Read with bl_i=blb_i=32'hFFFF_FFFF: rsp_rdata=0, rsp_err=1.
- Hold rsp_ready=0 for 4 cycles: rsp_valid and rsp_rdata stay stable; req_ready=0 throughout; a new req_valid is ignored.
- Pull wb_rst_n low during ACC: wl_o=0 and bl_oe=0 in the same cycle; no rsp_valid ever appears; the next request completes normally.
- PRE_CYC=1, WL_CYC=1, REC_CYC=1: rsp_valid at T+4; a monitor flags any cycle with popcount(wl_o)>1 or with wl_o nonzero during PRE.
